// File: rtl/sid_pot_sequencer.sv
// rtl/sid_pot_sequencer.sv - POTX/POTY discharge/count sequencer, one step per phi2 fall.
// Optional charged-input glitch filter: define SID_POT_FILTER_EN.
module sid_pot_sequencer #(
    parameter int DISCHARGE_CYCLES = 256,
    parameter int COUNT_CYCLES     = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       phi2,
    input  logic [1:0] charged,
    output logic       discharge,
    output logic [7:0] pot_x,
    output logic [7:0] pot_y,
    output logic       pot_valid
);

    typedef enum logic {
        ST_DISCHARGE = 1'b0,
        ST_COUNT     = 1'b1
    } state_t;

    localparam logic [8:0] DIS_LAST = 9'(DISCHARGE_CYCLES - 1);
    localparam logic [8:0] CNT_LAST = 9'(COUNT_CYCLES - 1);

    state_t          state_q, state_d;
    logic            phi2_prev_q, phi2_prev_d;
    logic            tick_q, tick_d;
    logic [8:0]      phase_q, phase_d;
    logic [1:0][7:0] cnt_q, cnt_d;
    logic [1:0]      done_q, done_d;
    logic            publish_q, publish_d;
    logic [7:0]      pot_x_q, pot_x_d;
    logic [7:0]      pot_y_q, pot_y_d;
    logic            pot_valid_q, pot_valid_d;
    logic [1:0]      charged_f;
    logic            last_dis;
    logic            last_cnt;

`ifdef SID_POT_FILTER_EN
    // Three-sample window: the live input plus two delayed copies must all be high.
    logic [1:0] stg1_q, stg1_d;
    logic [1:0] stg2_q, stg2_d;

    always_comb begin
        stg1_d    = charged;
        stg2_d    = stg1_q;
        charged_f = charged & stg1_q & stg2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg1_q <= 2'b00;
            stg2_q <= 2'b00;
        end else begin
            stg1_q <= stg1_d;
            stg2_q <= stg2_d;
        end
    end
`else
    always_comb begin
        charged_f = charged;
    end
`endif

    always_comb begin
        phi2_prev_d = phi2;
        tick_d      = phi2_prev_q & ~phi2;
        last_dis    = (phase_q == DIS_LAST);
        last_cnt    = (phase_q == CNT_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_DISCHARGE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (tick_q) begin
            case (state_q)
                ST_DISCHARGE: if (last_dis) state_d = ST_COUNT;
                ST_COUNT:     if (last_cnt) state_d = ST_DISCHARGE;
                default:      state_d = ST_DISCHARGE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        discharge = (state_q == ST_DISCHARGE);
        pot_x     = pot_x_q;
        pot_y     = pot_y_q;
        pot_valid = pot_valid_q;
    end

    // Counter datapath; a channel's count freezes once done, so the count is its result.
    always_comb begin
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        publish_d   = 1'b0;
        pot_x_d     = pot_x_q;
        pot_y_d     = pot_y_q;
        pot_valid_d = 1'b0;

        if (publish_q) begin
            pot_x_d     = cnt_q[0];
            pot_y_d     = cnt_q[1];
            pot_valid_d = 1'b1;
        end

        if (tick_q) begin
            phase_d = phase_q + 9'd1;
            if (state_q == ST_DISCHARGE) begin
                if (last_dis) begin
                    phase_d = 9'd0;
                    cnt_d   = '0;
                    done_d  = 2'b00;
                end
            end else begin
                for (int ch = 0; ch < 2; ch++) begin
                    if (!done_q[ch]) begin
                        if (charged_f[ch]) begin
                            done_d[ch] = 1'b1;
                        end else if (last_cnt) begin
                            cnt_d[ch] = 8'hFF;
                        end else if (cnt_q[ch] != 8'hFF) begin
                            cnt_d[ch] = cnt_q[ch] + 8'd1;
                        end
                    end
                end
                if (last_cnt) begin
                    phase_d   = 9'd0;
                    publish_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phi2_prev_q <= 1'b0;
            tick_q      <= 1'b0;
            phase_q     <= 9'd0;
            cnt_q       <= '0;
            done_q      <= 2'b00;
            publish_q   <= 1'b0;
            pot_x_q     <= 8'd0;
            pot_y_q     <= 8'd0;
            pot_valid_q <= 1'b0;
        end else begin
            phi2_prev_q <= phi2_prev_d;
            tick_q      <= tick_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            publish_q   <= publish_d;
            pot_x_q     <= pot_x_d;
            pot_y_q     <= pot_y_d;
            pot_valid_q <= pot_valid_d;
        end
    end

endmodule
